// File: rtl/stream_test_sink_if.sv
// Stream handshake bundle between a message producer and the test sink.
//   val : producer has a message this cycle
//   rdy : consumer accepts a message this cycle if val is also high
//   msg : message payload
// master: the producer side (drives val/msg). slave: the consumer side (drives rdy).
interface stream_test_sink_if #(
  parameter int unsigned p_msg_nbits = 32
) ();
  logic                   val;
  logic                   rdy;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/stream_test_sink.sv
// Stream sink for unit test benches. Holds a table of expected messages, accepts the DUT's
// output stream over val/rdy (optionally with pseudo-random backpressure) and compares every
// accepted message against the table.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_load_en      : append i_load_msg to the expected table (LOAD state only)
//   i_load_msg     : expected message
//   i_start        : end loading, begin receiving
//   recv           : slave side of the DUT output stream (val/rdy/msg)
//   o_done         : all expected messages received (sticky until reset)
//   o_err          : one-cycle pulse following each mismatching accept
//   o_num_recv     : messages accepted
//   o_num_errors   : mismatches, saturating
module stream_test_sink #(
  parameter int unsigned p_msg_nbits  = 32,
  parameter int unsigned p_max_msgs   = 64,
  parameter int unsigned p_rand_delay = 0,
  parameter int unsigned p_max_delay  = 3
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_load_en,
  input  logic [p_msg_nbits-1:0]            i_load_msg,
  input  logic                              i_start,
  stream_test_sink_if.slave                 recv,
  output logic                              o_done,
  output logic                              o_err,
  output logic [$clog2(p_max_msgs+1)-1:0]   o_num_recv,
  output logic [15:0]                       o_num_errors
);

  localparam int unsigned CW = $clog2(p_max_msgs + 1);
  localparam int unsigned AW = (p_max_msgs > 1) ? $clog2(p_max_msgs) : 1;
  localparam int unsigned DW = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;
  localparam logic [CW-1:0] MaxMsgs = CW'(p_max_msgs);
  localparam logic [15:0]   LfsrSeed = 16'hBEEF;
  localparam logic [15:0]   LfsrMask = 16'hB400;

  typedef enum logic [1:0] {StLoad, StRun, StDone} state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [CW-1:0]          r_num_exp;
  logic [CW-1:0]          r_recv_ptr;
  logic [CW-1:0]          r_num_recv;
  logic [DW-1:0]          r_delay_cnt;
  logic [15:0]            r_lfsr;
  logic [15:0]            r_num_errors;
  logic                   r_err;
  logic [p_msg_nbits-1:0] r_table [p_max_msgs];

  logic w_load;
  logic w_rdy;
  logic w_fire;
  logic w_mismatch;
  logic w_last;

  assign w_load = (r_state == StLoad) && i_load_en && (r_num_exp < MaxMsgs);
  // rdy comes only from registered state, never from recv.val.
  assign w_rdy  = (r_state == StRun) && (r_delay_cnt == '0) && (r_recv_ptr < r_num_exp);
  assign w_fire = recv.val && w_rdy;
  // Case inequality so X/Z bits on the DUT data are flagged (a plain compare in synthesis).
  assign w_mismatch = (recv.msg !== r_table[r_recv_ptr[AW-1:0]]);
  assign w_last     = ((r_recv_ptr + CW'(1)) == r_num_exp);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StLoad: begin
        if (i_start) begin
          // Empty table goes straight to DONE so done rises the cycle after start.
          w_state_next = ((r_num_exp == '0) && !i_load_en) ? StDone : StRun;
        end
      end
      StRun: begin
        if ((r_num_exp == '0) || (w_fire && w_last)) w_state_next = StDone;
      end
      StDone:  w_state_next = StDone;
      default: w_state_next = StLoad;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StLoad;
      r_num_exp    <= '0;
      r_recv_ptr   <= '0;
      r_num_recv   <= '0;
      r_delay_cnt  <= '0;
      r_lfsr       <= LfsrSeed;
      r_num_errors <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_fire && w_mismatch;
      if (w_load) r_num_exp <= r_num_exp + CW'(1);
      // Galois LFSR only runs in RUN so the rdy pattern depends only on time since start.
      if (r_state == StRun) begin
        r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LfsrMask : 16'h0000);
      end
      if (w_fire) begin
        r_recv_ptr  <= r_recv_ptr + CW'(1);
        r_num_recv  <= r_num_recv + CW'(1);
        r_delay_cnt <= (p_rand_delay != 0) ? DW'({16'h0000, r_lfsr} % (p_max_delay + 1)) : '0;
        if (w_mismatch && (r_num_errors != 16'hFFFF)) r_num_errors <= r_num_errors + 16'd1;
      end else if (r_delay_cnt != '0) begin
        r_delay_cnt <= r_delay_cnt - DW'(1);
      end
    end
  end

  // Table contents survive reset; only the fill pointer is cleared.
  always_ff @(posedge i_clk) begin
    if (w_load && !i_rst) r_table[r_num_exp[AW-1:0]] <= i_load_msg;
  end

  assign recv.rdy     = w_rdy;
  assign o_done       = (r_state == StDone);
  assign o_err        = r_err;
  assign o_num_recv   = r_num_recv;
  assign o_num_errors = r_num_errors;

endmodule

// File: tb/tb_stream_test_sink.sv
// Directed bench for stream_test_sink: one instance with backpressure off, one with it on.
module tb_stream_test_sink;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_load_en, a_start, a_done, a_err;
  logic [W-1:0]  a_load_msg;
  logic [CW-1:0] a_num_recv;
  logic [15:0]   a_num_errors;
  logic          b_load_en, b_start, b_done, b_err;
  logic [W-1:0]  b_load_msg;
  logic [CW-1:0] b_num_recv;
  logic [15:0]   b_num_errors;

  stream_test_sink_if #(.p_msg_nbits(W)) a_if ();
  stream_test_sink_if #(.p_msg_nbits(W)) b_if ();

  stream_test_sink #(
    .p_msg_nbits(W), .p_max_msgs(64), .p_rand_delay(0), .p_max_delay(3)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_load_en(a_load_en), .i_load_msg(a_load_msg),
    .i_start(a_start), .recv(a_if), .o_done(a_done), .o_err(a_err),
    .o_num_recv(a_num_recv), .o_num_errors(a_num_errors)
  );

  stream_test_sink #(
    .p_msg_nbits(W), .p_max_msgs(64), .p_rand_delay(1), .p_max_delay(3)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_load_en(b_load_en), .i_load_msg(b_load_msg),
    .i_start(b_start), .recv(b_if), .o_done(b_done), .o_err(b_err),
    .o_num_recv(b_num_recv), .o_num_errors(b_num_errors)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    a_load_en = 1'b0; a_start = 1'b0; a_load_msg = '0; a_if.val = 1'b0; a_if.msg = '0;
    b_load_en = 1'b0; b_start = 1'b0; b_load_msg = '0; b_if.val = 1'b0; b_if.msg = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_a(input logic [W-1:0] m);
    a_load_en = 1'b1; a_load_msg = m;
    tick();
    a_load_en = 1'b0;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic check_a_reset(input string tag);
    check_eq({tag, " rdy"},        a_if.rdy,     1'b0);
    check_eq({tag, " done"},       a_done,       1'b0);
    check_eq({tag, " err"},        a_err,        1'b0);
    check_eq({tag, " num_recv"},   a_num_recv,   '0);
    check_eq({tag, " num_errors"}, a_num_errors, '0);
  endtask

  int gaps [8];

  // Streams 8 messages into dut_b with val held high; records the rdy trace and rdy-low gaps.
  task automatic run_rand(output logic [63:0] trace, output int fires);
    int gap;
    reset_all();
    for (int i = 0; i < 8; i++) begin
      b_load_en = 1'b1; b_load_msg = 32'(i * 3 + 1);
      tick();
    end
    b_load_en = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_if.val = 1'b1;
    fires = 0;
    gap = 0;
    trace = '0;
    for (int i = 0; i < 8; i++) gaps[i] = -1;
    for (int c = 0; c < 64 && !b_done; c++) begin
      b_if.msg = 32'(fires * 3 + 1);
      trace[c] = b_if.rdy;
      if (b_if.rdy) begin
        if (fires > 0 && fires <= 8) gaps[fires-1] = gap;
        gap = 0;
        fires++;
      end else begin
        gap++;
      end
      tick();
    end
    b_if.val = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        err_seen;
    logic [63:0] trace1, trace2;
    int          fires1, fires2, max_gap;

    // In-order match, one message per cycle.
    reset_all();
    check_a_reset("reset");
    for (int i = 1; i <= 4; i++) load_a(32'(i));
    start_a();
    a_if.val = 1'b1;
    err_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_if.msg = 32'(i + 1);
      check_eq("inorder rdy", a_if.rdy, 1'b1);
      check_eq("inorder done early", a_done, 1'b0);
      tick();
      err_seen |= a_err;
    end
    check_eq("inorder done", a_done, 1'b1);
    check_eq("inorder num_recv", a_num_recv, 7'd4);
    check_eq("inorder num_errors", a_num_errors, 16'd0);
    check_eq("inorder err seen", err_seen, 1'b0);
    check_eq("inorder rdy after done", a_if.rdy, 1'b0);
    a_if.val = 1'b0;

    // Single mismatch.
    reset_all();
    load_a(32'hA);
    load_a(32'hC);
    start_a();
    a_if.val = 1'b1;
    a_if.msg = 32'hB;
    check_eq("mismatch rdy", a_if.rdy, 1'b1);
    tick();
    check_eq("mismatch err", a_err, 1'b1);
    check_eq("mismatch num_errors", a_num_errors, 16'd1);
    check_eq("mismatch num_recv", a_num_recv, 7'd1);
    check_eq("mismatch done early", a_done, 1'b0);
    a_if.msg = 32'hC;
    tick();
    check_eq("mismatch err one cycle", a_err, 1'b0);
    check_eq("mismatch final num_errors", a_num_errors, 16'd1);
    check_eq("mismatch done", a_done, 1'b1);
    check_eq("mismatch final num_recv", a_num_recv, 7'd2);
    a_if.val = 1'b0;

    // Unknown data must count as a mismatch.
    reset_all();
    load_a(32'h5);
    start_a();
    a_if.val = 1'b1;
    a_if.msg = 'x;
    tick();
    check_eq("xdata err", a_err, 1'b1);
    check_eq("xdata num_errors", a_num_errors, 16'd1);
    check_eq("xdata done", a_done, 1'b1);
    a_if.val = 1'b0;
    tick();
    check_eq("xdata err drop", a_err, 1'b0);

    // Empty table.
    reset_all();
    start_a();
    check_eq("empty done", a_done, 1'b1);
    check_eq("empty rdy", a_if.rdy, 1'b0);
    a_if.val = 1'b1;
    a_if.msg = 32'h1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("empty rdy held", a_if.rdy, 1'b0);
    end
    check_eq("empty num_recv", a_num_recv, 7'd0);
    check_eq("empty done held", a_done, 1'b1);
    a_if.val = 1'b0;

    // Reset in the middle of a run, then reload and finish.
    reset_all();
    for (int i = 1; i <= 4; i++) load_a(32'(i));
    start_a();
    a_if.val = 1'b1;
    a_if.msg = 32'h1;
    tick();
    a_if.msg = 32'h2;
    tick();
    check_eq("midrst num_recv before", a_num_recv, 7'd2);
    rst = 1'b1;
    a_if.msg = 32'h3;
    tick();
    rst = 1'b0;
    check_a_reset("midrst");
    a_if.val = 1'b0;
    load_a(32'h7);
    load_a(32'h8);
    start_a();
    check_eq("midrst rdy after start", a_if.rdy, 1'b1);
    a_if.val = 1'b1;
    a_if.msg = 32'h7;
    tick();
    a_if.msg = 32'h8;
    tick();
    check_eq("midrst done", a_done, 1'b1);
    check_eq("midrst num_recv", a_num_recv, 7'd2);
    check_eq("midrst num_errors", a_num_errors, 16'd0);
    a_if.val = 1'b0;

    // Random backpressure: LFSR BEEF -> delays 3, 2, 1 for the first three accepts.
    run_rand(trace1, fires1);
    check_eq("rand fires", 64'(fires1), 64'd8);
    check_eq("rand done", b_done, 1'b1);
    check_eq("rand num_recv", b_num_recv, 7'd8);
    check_eq("rand num_errors", b_num_errors, 16'd0);
    check_eq("rand first rdy", trace1[0], 1'b1);
    check_eq("rand gap0", 64'(gaps[0]), 64'd3);
    check_eq("rand gap1", 64'(gaps[1]), 64'd2);
    check_eq("rand gap2", 64'(gaps[2]), 64'd1);
    max_gap = 0;
    for (int i = 0; i < 7; i++) if (gaps[i] > max_gap || gaps[i] < 0) max_gap = gaps[i] < 0 ? 99 : gaps[i];
    check_eq("rand gap bound exceeded", 64'(max_gap > 3), 64'd0);
    run_rand(trace2, fires2);
    check_eq("rand repeat fires", 64'(fires2), 64'd8);
    check_eq("rand repeat trace", trace2, trace1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
